// File: rtl/pfb_mac_rnd_sat_if.sv
// PFB MAC output stage bundle: MAC result input, ce back-pressure and AXI-Stream output.
interface pfb_mac_rnd_sat_if #(
  parameter int unsigned IN_WIDTH   = 48,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned USER_WIDTH = 8
);
  logic signed [IN_WIDTH-1:0]   p_in;
  logic                         p_valid;
  logic                         p_last;
  logic [USER_WIDTH-1:0]        p_user;
  logic                         ce_out;
  logic [OUT_WIDTH-1:0]         m_axis_tdata;
  logic                         m_axis_tvalid;
  logic                         m_axis_tready;
  logic                         m_axis_tlast;
  logic [USER_WIDTH-1:0]        m_axis_tuser;

  // Output stage: consumes the MAC result, masters the AXI-Stream.
  modport master (
    input  p_in, p_valid, p_last, p_user, m_axis_tready,
    output ce_out, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  // Environment: MAC chain plus AXI-Stream sink.
  modport slave (
    output p_in, p_valid, p_last, p_user, m_axis_tready,
    input  ce_out, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/pfb_mac_rnd_sat.sv
// PFB MAC chain output stage: round-half-up, saturate, FWFT FIFO buffering to an
// AXI-Stream master, and ce back-pressure sized so in-flight MAC results are never lost.
module pfb_mac_rnd_sat #(
  parameter int unsigned IN_WIDTH   = 48,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned FRAC_SHIFT = 30,
  parameter int unsigned USER_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PIPE_SLACK = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  pfb_mac_rnd_sat_if.master      bus,
  input  logic                   clr_stats,
  output logic [15:0]            sat_count,
  output logic                   fifo_ovf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned RW = IN_WIDTH + 1;
  localparam int unsigned QW = RW - FRAC_SHIFT;
  localparam int unsigned EW = OUT_WIDTH + USER_WIDTH + 1;
  localparam int unsigned FW = AW + 3;

  localparam logic signed [RW-1:0] RND_BIAS = RW'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [QW-1:0] Q_MAX    = QW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [QW-1:0] Q_MIN    = -QW'(2 ** (OUT_WIDTH - 1));
  localparam logic [OUT_WIDTH-1:0] OUT_MAX  = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN  = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  // Stage R
  logic signed [RW-1:0]   rnd_c;
  logic                   rnd_frac_unused;
  logic signed [QW-1:0]   r_q;
  logic                   r_valid;
  logic                   r_last;
  logic [USER_WIDTH-1:0]  r_user;

  // Stage S
  logic                   sat_hi_c;
  logic                   sat_lo_c;
  logic [OUT_WIDTH-1:0]   s_data_c;
  logic [OUT_WIDTH-1:0]   s_data;
  logic                   s_valid;
  logic                   s_last;
  logic [USER_WIDTH-1:0]  s_user;

  // FIFO
  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [EW-1:0]          head_c;
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [AW:0]            occ_c;
  logic                   empty_c;
  logic                   full_c;
  logic                   pop_c;
  logic                   push_c;
  logic                   drop_c;
  logic signed [FW-1:0]   free_c;
  logic                   ce_q;

  // Rounding add at IN_WIDTH+1 bits; the fraction bits only contribute their carry.
  always_comb begin
    rnd_c = RW'(bus.p_in) + RND_BIAS;
  end

  assign rnd_frac_unused = ^rnd_c[FRAC_SHIFT-1:0];

  // Stage R register: keep the rounded quotient with its sideband.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q     <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_user  <= '0;
    end else begin
      r_q     <= rnd_c[RW-1:FRAC_SHIFT];
      r_valid <= bus.p_valid;
      r_last  <= bus.p_last;
      r_user  <= bus.p_user;
    end
  end

  // Saturation clamp of the rounded quotient.
  always_comb begin
    sat_hi_c = (r_q > Q_MAX);
    sat_lo_c = (r_q < Q_MIN);
    s_data_c = r_q[OUT_WIDTH-1:0];
    if (sat_hi_c) begin
      s_data_c = OUT_MAX;
    end else if (sat_lo_c) begin
      s_data_c = OUT_MIN;
    end
  end

  // Stage S register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_data  <= '0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      s_user  <= '0;
    end else begin
      s_data  <= s_data_c;
      s_valid <= r_valid;
      s_last  <= r_last;
      s_user  <= r_user;
    end
  end

  // Saturation counter; clear wins over a same-cycle increment, sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count <= '0;
    end else if (clr_stats) begin
      sat_count <= '0;
    end else if (r_valid && (sat_hi_c || sat_lo_c) && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

  // FIFO status, handshake and remaining headroom including words still in R/S.
  always_comb begin
    occ_c   = wr_ptr - rd_ptr;
    empty_c = (wr_ptr == rd_ptr);
    full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop_c   = !empty_c && bus.m_axis_tready;
    push_c  = s_valid && (!full_c || pop_c);
    drop_c  = s_valid && full_c && !pop_c;
    free_c  = FW'(FIFO_DEPTH) - FW'(occ_c) - FW'(r_valid) - FW'(s_valid);
    head_c  = mem[rd_ptr[AW-1:0]];
  end

  // FIFO storage and pointers; a write into a full FIFO is allowed only alongside a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_c) begin
        mem[wr_ptr[AW-1:0]] <= {s_last, s_user, s_data};
        wr_ptr              <= wr_ptr + (AW + 1)'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
    end
  end

  // Sticky drop flag, cleared by clr_stats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_ovf <= 1'b0;
    end else if (clr_stats) begin
      fifo_ovf <= 1'b0;
    end else if (drop_c) begin
      fifo_ovf <= 1'b1;
    end
  end

  // Upstream clock enable: advance only while headroom exceeds the in-flight slack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_q <= 1'b1;
    end else begin
      ce_q <= (free_c > $signed(FW'(PIPE_SLACK)));
    end
  end

  assign bus.ce_out        = ce_q;
  assign bus.m_axis_tvalid = !empty_c;
  assign bus.m_axis_tdata  = head_c[OUT_WIDTH-1:0];
  assign bus.m_axis_tuser  = head_c[OUT_WIDTH +: USER_WIDTH];
  assign bus.m_axis_tlast  = head_c[EW-1];

endmodule
